// File: rtl/add4_accum_if.sv
// Handshake bundle between the 4-bit adder source, the frame accumulator and
// the frame consumer. The accumulator takes the slave modport.
interface add4_accum_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] q_in;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic [4:0] out_count;

  modport master (
    output in_valid, q_in, flush, out_ready,
    input  in_ready, out_valid, acc_out, out_count
  );

  modport slave (
    input  in_valid, q_in, flush, out_ready,
    output in_ready, out_valid, acc_out, out_count
  );
endinterface

// File: rtl/add4_accum.sv
// Accumulates BURST_LEN 4-bit sums (or fewer on flush) into one 8-bit frame total.
// Optional macro ADD4_ACCUM_SKID_EN: accept the next frame's first sum while emitting.
module add4_accum #(
  parameter int BURST_LEN = 4
) (
  input logic          clk,
  input logic          rst_n,
  add4_accum_if.slave  s_if
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [4:0] BURST_CNT = 5'(BURST_LEN);

  state_t     r_state;
  logic [7:0] r_acc;
  logic [4:0] r_cnt;
  logic       r_out_valid;
  logic [7:0] r_acc_out;
  logic [4:0] r_out_count;

  logic       w_in_fire;
  logic       w_out_fire;
  logic [7:0] w_q_ext;
  logic [7:0] w_acc_sum;
  logic [4:0] w_cnt_inc;

`ifdef ADD4_ACCUM_SKID_EN
  assign s_if.in_ready = (r_state == HOLD) ? s_if.out_ready : 1'b1;
`else
  assign s_if.in_ready = (r_state != HOLD);
`endif

  assign w_in_fire  = s_if.in_valid & s_if.in_ready;
  assign w_out_fire = r_out_valid & s_if.out_ready;
  assign w_q_ext    = {4'd0, s_if.q_in};
  assign w_acc_sum  = r_acc + w_q_ext;
  assign w_cnt_inc  = r_cnt + 5'd1;

  assign s_if.out_valid = r_out_valid;
  assign s_if.acc_out   = r_acc_out;
  assign s_if.out_count = r_out_count;

  // Output registers are loaded on the edge that enters HOLD, so a frame is
  // visible one cycle after its last sum and reads zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= 8'd0;
      r_cnt       <= 5'd0;
      r_out_valid <= 1'b0;
      r_acc_out   <= 8'd0;
      r_out_count <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_acc <= w_q_ext;
            r_cnt <= 5'd1;
            if (BURST_CNT == 5'd1) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_acc_out   <= w_q_ext;
              r_out_count <= 5'd1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_in_fire) begin
            r_acc <= w_acc_sum;
            r_cnt <= w_cnt_inc;
          end
          // A sum accepted on the flush edge still belongs to this frame.
          if ((w_in_fire && (w_cnt_inc == BURST_CNT)) || s_if.flush) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_acc_out   <= w_in_fire ? w_acc_sum : r_acc;
            r_out_count <= w_in_fire ? w_cnt_inc : r_cnt;
          end
        end
        HOLD: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_acc_out   <= 8'd0;
            r_out_count <= 5'd0;
            r_acc       <= 8'd0;
            r_cnt       <= 5'd0;
            r_state     <= IDLE;
`ifdef ADD4_ACCUM_SKID_EN
            if (w_in_fire) begin
              r_acc <= w_q_ext;
              r_cnt <= 5'd1;
              if (BURST_CNT == 5'd1) begin
                r_state     <= HOLD;
                r_out_valid <= 1'b1;
                r_acc_out   <= w_q_ext;
                r_out_count <= 5'd1;
              end else begin
                r_state <= ACCUM;
              end
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add4_accum.sv
// Directed bench for add4_accum: four instances (BURST_LEN 4/16/2/1) share one
// stimulus stream; each scenario task checks the instance it targets.
module tb_add4_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] q_in = 4'd0;
  int         total = 0;
  int         bad = 0;

`ifdef ADD4_ACCUM_SKID_EN
  localparam int EXP_PERIOD = 2;
  localparam int EXP_FRAMES = 6;
`else
  localparam int EXP_PERIOD = 3;
  localparam int EXP_FRAMES = 4;
`endif

  always #5 clk = ~clk;

  add4_accum_if if4 ();
  add4_accum_if if16 ();
  add4_accum_if if2 ();
  add4_accum_if if1 ();

  assign if4.in_valid  = in_valid;
  assign if4.q_in      = q_in;
  assign if4.flush     = flush;
  assign if4.out_ready = out_ready;
  assign if16.in_valid  = in_valid;
  assign if16.q_in      = q_in;
  assign if16.flush     = flush;
  assign if16.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.q_in      = q_in;
  assign if2.flush     = flush;
  assign if2.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.q_in      = q_in;
  assign if1.flush     = flush;
  assign if1.out_ready = out_ready;

  add4_accum #(.BURST_LEN(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .s_if(if4.slave));
  add4_accum #(.BURST_LEN(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .s_if(if16.slave));
  add4_accum #(.BURST_LEN(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .s_if(if2.slave));
  add4_accum #(.BURST_LEN(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .s_if(if1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; q_in = 4'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [3:0] v);
    in_valid = 1'b1;
    q_in = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; q_in = 4'd0;
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", if4.out_valid); end
    total++; if (if4.acc_out !== 8'd0) begin bad++; $display("FAIL reset_acc: got %0d expected 0", if4.acc_out); end
    total++; if (if4.out_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", if4.out_count); end
    rst_n = 1'b1;
    tick();
    total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b expected 1", if4.in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    send(4'd3); send(4'd5); send(4'd7);
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %0b expected 0", if4.out_valid); end
    send(4'd9);
    total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b expected 1", if4.out_valid); end
    total++; if (if4.acc_out !== 8'd24) begin bad++; $display("FAIL basic_acc: got %0d expected 24", if4.acc_out); end
    total++; if (if4.out_count !== 5'd4) begin bad++; $display("FAIL basic_count: got %0d expected 4", if4.out_count); end
    total++; if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_hold: got %0b expected 0", if4.in_ready); end
    drain();
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain_valid: got %0b expected 0", if4.out_valid); end
    total++; if (if4.acc_out !== 8'd0) begin bad++; $display("FAIL basic_drain_acc: got %0d expected 0", if4.acc_out); end
    $display("basic: 3+5+7+9 frame checked");
  endtask

  task automatic test_max();
    do_reset();
    for (int i = 0; i < 15; i++) send(4'd15);
    total++; if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL max_early_valid: got %0b expected 0", if16.out_valid); end
    send(4'd15);
    total++; if (if16.out_valid !== 1'b1) begin bad++; $display("FAIL max_valid: got %0b expected 1", if16.out_valid); end
    total++; if (if16.acc_out !== 8'd240) begin bad++; $display("FAIL max_acc: got %0d expected 240", if16.acc_out); end
    total++; if (if16.out_count !== 5'd16) begin bad++; $display("FAIL max_count: got %0d expected 16", if16.out_count); end
    drain();
    $display("max: sixteen 15s checked");
  endtask

  task automatic test_flush();
    do_reset();
    send(4'd2); send(4'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL flush_valid: got %0b expected 1", if4.out_valid); end
    total++; if (if4.acc_out !== 8'd6) begin bad++; $display("FAIL flush_acc: got %0d expected 6", if4.acc_out); end
    total++; if (if4.out_count !== 5'd2) begin bad++; $display("FAIL flush_count: got %0d expected 2", if4.out_count); end
    drain();
    send(4'd2); send(4'd4);
    in_valid = 1'b1; q_in = 4'd1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    total++; if (if4.acc_out !== 8'd7) begin bad++; $display("FAIL flush_concurrent_acc: got %0d expected 7", if4.acc_out); end
    total++; if (if4.out_count !== 5'd3) begin bad++; $display("FAIL flush_concurrent_count: got %0d expected 3", if4.out_count); end
    drain();
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_valid: got %0b expected 0", if4.out_valid); end
    $display("flush: partial frames 6/2 and 7/3 checked");
  endtask

  task automatic test_hold_stall();
    do_reset();
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    in_valid = 1'b1; q_in = 4'd5;
    for (int i = 0; i < 5; i++) begin
      total++; if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", i, if4.in_ready); end
      total++; if (if4.acc_out !== 8'd10 || if4.out_count !== 5'd4 || if4.out_valid !== 1'b1)
        begin bad++; $display("FAIL stall_outputs[%0d]: got %0d/%0d/%0b expected 10/4/1", i, if4.acc_out, if4.out_count, if4.out_valid); end
      tick();
    end
    in_valid = 1'b0;
    drain();
    total++; if (if4.out_valid !== 1'b0 || if4.acc_out !== 8'd0 || if4.out_count !== 5'd0)
      begin bad++; $display("FAIL stall_release: got %0b/%0d/%0d expected 0/0/0", if4.out_valid, if4.acc_out, if4.out_count); end
    total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL stall_idle_ready: got %0b expected 1", if4.in_ready); end
    $display("hold_stall: 5-cycle backpressure checked");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(4'd8); send(4'd8);
    total++; if (if2.acc_out !== 8'd16) begin bad++; $display("FAIL rstmid_pre_acc: got %0d expected 16", if2.acc_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (if2.out_valid !== 1'b0 || if2.acc_out !== 8'd0 || if2.out_count !== 5'd0)
      begin bad++; $display("FAIL rstmid_async: got %0b/%0d/%0d expected 0/0/0", if2.out_valid, if2.acc_out, if2.out_count); end
    #2 rst_n = 1'b1;
    tick();
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    total++; if (if4.acc_out !== 8'd4 || if4.out_count !== 5'd4)
      begin bad++; $display("FAIL rstmid_next_frame: got %0d/%0d expected 4/4", if4.acc_out, if4.out_count); end
    drain();
    $display("reset_mid: frame discarded, next frame 4 checked");
  endtask

  task automatic test_burst1();
    do_reset();
    send(4'd7);
    total++; if (if1.out_valid !== 1'b1 || if1.acc_out !== 8'd7 || if1.out_count !== 5'd1)
      begin bad++; $display("FAIL burst1: got %0b/%0d/%0d expected 1/7/1", if1.out_valid, if1.acc_out, if1.out_count); end
    drain();
    $display("burst1: single-sum frame checked");
  endtask

  task automatic test_back_to_back();
    int last;
    int frames;
    do_reset();
    last = -1;
    frames = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    q_in = 4'd1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (if2.out_valid === 1'b1) begin
        frames++;
        total++; if (if2.acc_out !== 8'd2 || if2.out_count !== 5'd2)
          begin bad++; $display("FAIL b2b_frame@%0d: got %0d/%0d expected 2/2", c, if2.acc_out, if2.out_count); end
        if (last >= 0) begin
          total++; if (c - last !== EXP_PERIOD)
            begin bad++; $display("FAIL b2b_period@%0d: got %0d expected %0d", c, c - last, EXP_PERIOD); end
        end
        last = c;
      end
    end
    in_valid = 1'b0;
    total++; if (frames !== EXP_FRAMES) begin bad++; $display("FAIL b2b_frames: got %0d expected %0d", frames, EXP_FRAMES); end
    repeat (3) tick();
    out_ready = 1'b0;
    $display("back_to_back: %0d frames in 12 cycles", frames);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_flush();
    test_hold_stall();
    test_reset_mid();
    test_burst1();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add4_accum.md
ADD4_ACCUM -- requirements
Module: add4_accum

Interface
REQ-001 Parameter BURST_LEN, default 4, number of 4-bit sums per frame; legal range 1..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  q_in holds a valid 4-bit adder sum.
REQ-005 in_ready  output  1  block accepts q_in this cycle.
REQ-006 q_in  input  4  sum from upstream 4-bit adder, unsigned 0..15.
REQ-007 flush  input  1  ends a partial frame early.
REQ-008 out_valid  output  1  acc_out/out_count hold a completed frame.
REQ-009 out_ready  input  1  downstream accepts the frame.
REQ-010 acc_out  output  8  unsigned total of the frame's sums.
REQ-011 out_count  output  5  number of sums in the frame, 1..16.

Function
REQ-012 Input transfer occurs when in_valid and in_ready are both 1 at a rising edge; output transfer when out_valid and out_ready are both 1.
REQ-013 FSM states: IDLE, ACCUM, HOLD.
REQ-014 IDLE: in_ready=1, out_valid=0; on transfer acc=q_in, cnt=1, go to HOLD if BURST_LEN==1, else ACCUM.
REQ-015 ACCUM: in_ready=1; on transfer acc=acc+q_in, cnt=cnt+1; go to HOLD when new cnt equals BURST_LEN.
REQ-016 ACCUM with flush=1: go to HOLD next cycle with current acc/cnt; a same-cycle input transfer is included first (and counted).
REQ-017 flush in IDLE or HOLD has no effect; empty frames are never emitted.
REQ-018 HOLD: out_valid=1, acc_out=acc, out_count=cnt, in_ready=0 (except REQ-026); outputs stable until output transfer.
REQ-019 HOLD on output transfer: go to IDLE, acc and cnt cleared to 0.
REQ-020 Arithmetic: 8-bit unsigned, no saturation needed; max 16*15=240 fits, no overflow possible.
REQ-021 Latency: frame available on out_valid one cycle after the accepting edge of its final sum (or flush edge).
REQ-022 acc_out and out_count read 0 whenever out_valid=0.
REQ-023 in_ready is combinational from state (and out_ready under REQ-026) only; never from in_valid.

Reset
REQ-024 rst_n low asynchronously forces IDLE, acc=0, cnt=0, out_valid=0, acc_out=0, out_count=0; in_ready=1 after rst_n releases.
REQ-025 Reset mid-frame or in HOLD discards the frame; no partial output emitted after release.

Configuration
REQ-026 Macro ADD4_ACCUM_SKID_EN defined: in HOLD, in_ready=out_ready; a same-cycle input and output transfer emits the frame and loads acc=q_in, cnt=1, next state ACCUM (or HOLD if BURST_LEN==1), giving zero-bubble back-to-back frames.
REQ-027 Macro undefined: in HOLD in_ready=0; one IDLE cycle minimum between frames.

Verification
REQ-028 BURST_LEN=4, sums 3,5,7,9 back-to-back -> out_valid one cycle after 4th, acc_out=24, out_count=4.
REQ-029 BURST_LEN=16, sixteen sums of 15 -> acc_out=240, out_count=16, no wrap.
REQ-030 BURST_LEN=4, sums 2,4 then flush with in_valid=0 -> acc_out=6, out_count=2; flush with concurrent sum 1 -> acc_out=7, out_count=3.
REQ-031 Frame in HOLD, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> IDLE, outputs 0.
REQ-032 rst_n low mid-frame after sums 8,8 -> outputs 0 immediately; next frame 1,1,1,1 -> acc_out=4.
REQ-033 With ADD4_ACCUM_SKID_EN, out_ready=1 and continuous input, BURST_LEN=2 -> one frame every 2 cycles, no gap; without macro -> every 3 cycles.
